sweep_max_counter: RTL and testbench
====================================

Name: sweep_max_counter

Overview:
- Counter/peak-search companion to the tracker control FSM.
- Consumes the FSM's sweep enables (HS, VS, MC, CNT_RST) and produces the sweep-limit flags (CNT_L, CNT_D, CNT_RU) that the FSM polls.
- Paces servo steps with a prescaler, records the step position of peak irradiance during each sweep, then counts the return distance back to that peak.
- Sits between the XADC sample path and the FSM.

Parameters:
DATA_W, 12, irradiance sample width
STEP_W, 8, step counter width
H_STEPS, 180, horizontal sweep length in steps (< 2^STEP_W)
V_STEPS, 90, vertical sweep length in steps (< 2^STEP_W)
STEP_DIV, 100000, CLK cycles per servo step (>= 2)

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high; clock CLK
HS  in  1  horizontal sweep enable from FSM
VS  in  1  vertical sweep enable from FSM
MC  in  1  max-return enable from FSM
CNT_RST  in  1  counter clear from FSM (manual mode)
SAMPLE_VALID  in  1  one-cycle strobe, SAMPLE valid
SAMPLE  in  DATA_W  irradiance sample, unsigned
CNT_L  out  1  horizontal sweep steps remaining
CNT_D  out  1  vertical sweep steps remaining
CNT_RU  out  1  return steps remaining (shared right/up)
STEP_TICK  out  1  one-cycle pulse per completed step
MAX_VAL  out  DATA_W  peak sample of current/last sweep
MAX_POS  out  STEP_W  step index of that peak
MODE  out  2  0 IDLE, 1 HSWEEP, 2 VSWEEP, 3 RETURN

Behaviour:
- Reset (RST=1 at edge): MODE=IDLE; step_cnt, ret_cnt, prescaler, MAX_VAL, MAX_POS = 0; all flags and STEP_TICK = 0.
- RST has priority over CNT_RST.
- CNT_RST=1: MODE=IDLE and step_cnt/ret_cnt/prescaler cleared. MAX_VAL and MAX_POS are held for display.
- Mode entry is evaluated at each edge when CNT_RST=0. Input priority is MC > VS > HS.
- MC=1 and MODE!=RETURN:
  - MODE<=RETURN.
  - ret_cnt <= N - MAX_POS, where N is the length of the sweep just finished (H_STEPS if the previous MODE was HSWEEP, V_STEPS if VSWEEP, else 0).
  - If MAX_POS is updated in this same cycle, use the updated value.
- VS=1 (MC=0) and MODE!=VSWEEP: MODE<=VSWEEP; step_cnt, MAX_VAL, MAX_POS <= 0.
- HS=1 (MC=0, VS=0) and MODE!=HSWEEP: MODE<=HSWEEP; same clears.
- HS=VS=MC=0: MODE<=IDLE.
- Mode-entry latency is one cycle:
  - A flag is valid the cycle after its enable first rises.
  - The FSM samples flags only in the state following the enable.
- Flags are combinational from registered state:
  - CNT_L = (MODE==HSWEEP && step_cnt<H_STEPS)
  - CNT_D = (MODE==VSWEEP && step_cnt<V_STEPS)
  - CNT_RU = (MODE==RETURN && ret_cnt!=0)
- Prescaler:
  - Counts only while the active flag is 1.
  - At count STEP_DIV-1 it wraps to 0 and pulses STEP_TICK for one cycle.
  - Cleared on every mode change.
  - First tick occurs STEP_DIV cycles after mode entry.
- On STEP_TICK:
  - Sweep modes: step_cnt+1.
  - RETURN: ret_cnt-1.
  - Counters saturate: never exceed N, never go below 0.
- Peak capture:
  - Accepted when SAMPLE_VALID=1 in HSWEEP/VSWEEP while the sweep flag is 1, or on the edge where step_cnt equals N (final position).
  - If SAMPLE > MAX_VAL (strict, unsigned): MAX_VAL<=SAMPLE and MAX_POS<=step_cnt (pre-increment value if STEP_TICK coincides).
  - Ties keep the earliest position.
  - Samples in IDLE/RETURN are ignored.
- If no sample exceeds 0 during a sweep, MAX_POS=0 and the return distance is the full N.
- If MC drops while ret_cnt!=0 (abort), the block follows the enables: IDLE or the new sweep. ret_cnt is discarded.
- Switching HSWEEP->VSWEEP mid-sweep restarts the count and the peak search.

Test Plan:
- Params STEP_DIV=4, H_STEPS=8, V_STEPS=4. Assert RST for 2 cycles -> all outputs 0, MODE=0.
- Raise HS -> next cycle MODE=1, CNT_L=1. STEP_TICK every 4 cycles. CNT_L falls the cycle after the 8th tick (33 cycles after entry).
- During the H sweep, drive SAMPLE 100@step2, 300@step5, 300@step6, 50@step7 -> MAX_VAL=300, MAX_POS=5. Then raise MC -> CNT_RU=1 next cycle. ret_cnt=3, and CNT_RU falls after 3 ticks.
- Drop MC, raise VS with no samples -> MAX_VAL=0, MAX_POS=0, CNT_D high for 4 ticks. Then MC -> CNT_RU high for 4 ticks.
- SAMPLE_VALID=1 with value 900 on the same cycle as STEP_TICK at step_cnt=3 -> MAX_POS=3, not 4.
- Mid-RETURN with ret_cnt=2, assert CNT_RST -> MODE=0, CNT_RU=0 next cycle, MAX_VAL/MAX_POS retained. Assert RST mid-sweep -> all cleared.

Source files
------------

// File: rtl/sweep_max_counter_if.sv
// Handshake bundle between the tracker control FSM and sweep_max_counter.
// The FSM side (master) drives the sweep enables and XADC samples; the
// counter side (slave) returns the sweep-limit flags and peak record.
interface sweep_max_counter_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned STEP_W = 8
);
    logic              HS;
    logic              VS;
    logic              MC;
    logic              CNT_RST;
    logic              SAMPLE_VALID;
    logic [DATA_W-1:0] SAMPLE;
    logic              CNT_L;
    logic              CNT_D;
    logic              CNT_RU;
    logic              STEP_TICK;
    logic [DATA_W-1:0] MAX_VAL;
    logic [STEP_W-1:0] MAX_POS;
    logic [1:0]        MODE;

    modport master (
        output HS, VS, MC, CNT_RST, SAMPLE_VALID, SAMPLE,
        input  CNT_L, CNT_D, CNT_RU, STEP_TICK, MAX_VAL, MAX_POS, MODE
    );

    modport slave (
        input  HS, VS, MC, CNT_RST, SAMPLE_VALID, SAMPLE,
        output CNT_L, CNT_D, CNT_RU, STEP_TICK, MAX_VAL, MAX_POS, MODE
    );
endinterface

// File: rtl/sweep_max_counter.sv
// Sweep step counter and peak search for the tracker.
// Paces servo steps with a prescaler, records the step of peak irradiance
// during a horizontal or vertical sweep, then counts the return distance
// back to that peak. Flags are decoded combinationally from registered state.
module sweep_max_counter #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned STEP_W   = 8,
    parameter int unsigned H_STEPS  = 180,
    parameter int unsigned V_STEPS  = 90,
    parameter int unsigned STEP_DIV = 100000
) (
    input logic                 CLK,
    input logic                 RST,
    sweep_max_counter_if.slave  bus
);

    localparam int unsigned       PRE_W    = $clog2(STEP_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] H_N      = STEP_W'(H_STEPS);
    localparam logic [STEP_W-1:0] V_N      = STEP_W'(V_STEPS);

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_HSWEEP = 2'd1,
        M_VSWEEP = 2'd2,
        M_RETURN = 2'd3
    } mode_t;

    mode_t              mode_q;
    logic [STEP_W-1:0]  step_cnt_q;
    logic [STEP_W-1:0]  ret_cnt_q;
    logic [PRE_W-1:0]   presc_q;
    logic               tick_q;
    logic [DATA_W-1:0]  max_val_q;
    logic [STEP_W-1:0]  max_pos_q;

    logic [PRE_W-1:0]   presc_d;
    logic               tick_d;
    logic [DATA_W-1:0]  max_val_d;
    logic [STEP_W-1:0]  max_pos_d;
    logic [STEP_W-1:0]  ret_load_d;
    logic [STEP_W-1:0]  sweep_n;
    logic               cnt_l;
    logic               cnt_d;
    logic               cnt_ru;
    logic               flag_act;
    logic               capture;
    mode_t              sweep_tgt;

    // Flag decode, prescaler next state and peak-capture candidates.
    always_comb begin
        sweep_n    = '0;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        max_val_d  = max_val_q;
        max_pos_d  = max_pos_q;
        ret_load_d = '0;
        capture    = 1'b0;
        sweep_tgt  = bus.VS ? M_VSWEEP : M_HSWEEP;

        if (mode_q == M_HSWEEP) begin
            sweep_n = H_N;
        end else if (mode_q == M_VSWEEP) begin
            sweep_n = V_N;
        end

        cnt_l    = (mode_q == M_HSWEEP) && (step_cnt_q < H_N);
        cnt_d    = (mode_q == M_VSWEEP) && (step_cnt_q < V_N);
        cnt_ru   = (mode_q == M_RETURN) && (ret_cnt_q != '0);
        flag_act = cnt_l || cnt_d || cnt_ru;

        if (flag_act) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end

        // Samples count up to and including the final sweep position.
        capture = bus.SAMPLE_VALID
                  && ((mode_q == M_HSWEEP) || (mode_q == M_VSWEEP))
                  && (step_cnt_q <= sweep_n)
                  && (bus.SAMPLE > max_val_q);
        if (capture) begin
            max_val_d = bus.SAMPLE;
            max_pos_d = step_cnt_q;
        end

        // Return distance uses the peak position including this cycle's capture.
        if (max_pos_d < sweep_n) begin
            ret_load_d = sweep_n - max_pos_d;
        end
    end

    // Mode sequencing, step/return counting and peak registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q     <= M_IDLE;
            step_cnt_q <= '0;
            ret_cnt_q  <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            max_val_q  <= '0;
            max_pos_q  <= '0;
        end else if (bus.CNT_RST) begin
            mode_q     <= M_IDLE;
            step_cnt_q <= '0;
            ret_cnt_q  <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
        end else if (bus.MC) begin
            if (mode_q != M_RETURN) begin
                mode_q    <= M_RETURN;
                ret_cnt_q <= ret_load_d;
                max_val_q <= max_val_d;
                max_pos_q <= max_pos_d;
                presc_q   <= '0;
                tick_q    <= 1'b0;
            end else begin
                presc_q <= presc_d;
                tick_q  <= tick_d;
                if (tick_q && (ret_cnt_q != '0)) begin
                    ret_cnt_q <= ret_cnt_q - STEP_W'(1);
                end
            end
        end else if (bus.VS || bus.HS) begin
            if (mode_q != sweep_tgt) begin
                mode_q     <= sweep_tgt;
                step_cnt_q <= '0;
                ret_cnt_q  <= '0;
                presc_q    <= '0;
                tick_q     <= 1'b0;
                max_val_q  <= '0;
                max_pos_q  <= '0;
            end else begin
                presc_q   <= presc_d;
                tick_q    <= tick_d;
                max_val_q <= max_val_d;
                max_pos_q <= max_pos_d;
                if (tick_q && (step_cnt_q < sweep_n)) begin
                    step_cnt_q <= step_cnt_q + STEP_W'(1);
                end
            end
        end else begin
            mode_q  <= M_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end
    end

    assign bus.CNT_L     = cnt_l;
    assign bus.CNT_D     = cnt_d;
    assign bus.CNT_RU    = cnt_ru;
    assign bus.STEP_TICK = tick_q;
    assign bus.MAX_VAL   = max_val_q;
    assign bus.MAX_POS   = max_pos_q;
    assign bus.MODE      = mode_q;

endmodule

// File: tb/tb_sweep_max_counter.sv
// Directed bench for sweep_max_counter with STEP_DIV=4, H_STEPS=8, V_STEPS=4.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_sweep_max_counter;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned STEP_W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    sweep_max_counter_if #(.DATA_W(DATA_W), .STEP_W(STEP_W)) bus ();

    sweep_max_counter #(
        .DATA_W  (DATA_W),
        .STEP_W  (STEP_W),
        .H_STEPS (8),
        .V_STEPS (4),
        .STEP_DIV(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Count one comparison and report it if it does not hold.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.HS = 1'b0; bus.VS = 1'b0; bus.MC = 1'b0; bus.CNT_RST = 1'b0;
        bus.SAMPLE_VALID = 1'b0; bus.SAMPLE = '0;

        // Reset for two cycles
        step(); step();
        RST = 1'b0;
        check("rst_mode", 32'(bus.MODE), 0);
        check("rst_cntl", 32'(bus.CNT_L), 0);
        check("rst_cntd", 32'(bus.CNT_D), 0);
        check("rst_cntru", 32'(bus.CNT_RU), 0);
        check("rst_tick", 32'(bus.STEP_TICK), 0);
        check("rst_maxval", 32'(bus.MAX_VAL), 0);
        check("rst_maxpos", 32'(bus.MAX_POS), 0);

        // Horizontal sweep with samples at steps 2, 5, 6, 7
        bus.HS = 1'b1;
        step();
        check("h_mode", 32'(bus.MODE), 1);
        check("h_cntl0", 32'(bus.CNT_L), 1);
        check("h_tick0", 32'(bus.STEP_TICK), 0);
        for (int k = 1; k <= 36; k++) begin
            step();
            check("h_tick", 32'(bus.STEP_TICK), 32'((k % 4 == 0) && (k <= 32)));
            check("h_cntl", 32'(bus.CNT_L), 32'(k < 33));
            bus.SAMPLE_VALID = 1'b1;
            case (k)
                10:      bus.SAMPLE = 12'd100;
                22:      bus.SAMPLE = 12'd300;
                26:      bus.SAMPLE = 12'd300;
                30:      bus.SAMPLE = 12'd50;
                default: bus.SAMPLE_VALID = 1'b0;
            endcase
        end
        check("h_maxval", 32'(bus.MAX_VAL), 300);
        check("h_maxpos", 32'(bus.MAX_POS), 5);

        // Return to peak: 8 - 5 = 3 steps
        bus.MC = 1'b1;
        step();
        check("r1_mode", 32'(bus.MODE), 3);
        check("r1_cntru0", 32'(bus.CNT_RU), 1);
        for (int r = 1; r <= 16; r++) begin
            step();
            check("r1_tick", 32'(bus.STEP_TICK), 32'((r % 4 == 0) && (r <= 12)));
            check("r1_cntru", 32'(bus.CNT_RU), 32'(r < 13));
        end
        check("r1_maxpos", 32'(bus.MAX_POS), 5);

        // Vertical sweep with no samples
        bus.MC = 1'b0; bus.HS = 1'b0; bus.VS = 1'b1;
        step();
        check("v_mode", 32'(bus.MODE), 2);
        check("v_maxval", 32'(bus.MAX_VAL), 0);
        check("v_maxpos", 32'(bus.MAX_POS), 0);
        check("v_cntd0", 32'(bus.CNT_D), 1);
        for (int v = 1; v <= 20; v++) begin
            step();
            check("v_tick", 32'(bus.STEP_TICK), 32'((v % 4 == 0) && (v <= 16)));
            check("v_cntd", 32'(bus.CNT_D), 32'(v < 17));
        end

        // Return over the full vertical length: 4 steps
        bus.MC = 1'b1;
        step();
        check("r2_mode", 32'(bus.MODE), 3);
        for (int r = 1; r <= 20; r++) begin
            step();
            check("r2_cntru", 32'(bus.CNT_RU), 32'(r < 17));
        end

        // Second horizontal sweep: sample coincides with tick at step 3
        bus.MC = 1'b0; bus.VS = 1'b0; bus.HS = 1'b1;
        step();
        check("h2_mode", 32'(bus.MODE), 1);
        for (int k = 1; k <= 36; k++) begin
            step();
            bus.SAMPLE_VALID = 1'b0;
            if (k == 16) begin
                check("h2_tick16", 32'(bus.STEP_TICK), 1);
                bus.SAMPLE_VALID = 1'b1;
                bus.SAMPLE = 12'd900;
            end
        end
        check("h2_maxval", 32'(bus.MAX_VAL), 900);
        check("h2_maxpos", 32'(bus.MAX_POS), 3);

        // Return of 5 steps, cleared by CNT_RST with 2 steps left
        bus.MC = 1'b1;
        step();
        check("r3_cntru0", 32'(bus.CNT_RU), 1);
        for (int r = 1; r <= 14; r++) step();
        check("r3_cntru14", 32'(bus.CNT_RU), 1);
        bus.CNT_RST = 1'b1;
        step();
        check("crst_mode", 32'(bus.MODE), 0);
        check("crst_cntru", 32'(bus.CNT_RU), 0);
        check("crst_tick", 32'(bus.STEP_TICK), 0);
        check("crst_maxval", 32'(bus.MAX_VAL), 900);
        check("crst_maxpos", 32'(bus.MAX_POS), 3);
        bus.CNT_RST = 1'b0; bus.MC = 1'b0; bus.HS = 1'b0;
        step();
        check("idle_mode", 32'(bus.MODE), 0);

        // Synchronous reset in the middle of a sweep
        bus.HS = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            bus.SAMPLE_VALID = (k == 6);
            bus.SAMPLE = 12'd500;
        end
        bus.SAMPLE_VALID = 1'b0;
        check("pre_rst_maxval", 32'(bus.MAX_VAL), 500);
        check("pre_rst_maxpos", 32'(bus.MAX_POS), 1);
        RST = 1'b1;
        step();
        check("rst2_mode", 32'(bus.MODE), 0);
        check("rst2_cntl", 32'(bus.CNT_L), 0);
        check("rst2_tick", 32'(bus.STEP_TICK), 0);
        check("rst2_maxval", 32'(bus.MAX_VAL), 0);
        check("rst2_maxpos", 32'(bus.MAX_POS), 0);
        RST = 1'b0; bus.HS = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
